// File: rtl/uart_pkg.sv
// Shared types and defaults for the uart_tx arbiter.
// Optional launch timeout is enabled with `define UART_ARB_TIMEOUT_EN.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_TX = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int unsigned TIMEOUT_CYC_DFLT = 64;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin pick: first set request scanning from ptr upwards, modulo N_REQ.
module uart_rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             valid,
  output logic [PW-1:0]    w
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the nearest set request wins last.
  always_comb begin
    valid = |req;
    w     = '0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (req[idx]) w = idx;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers.
// `define UART_ARB_TIMEOUT_EN adds a launch timeout that aborts with ERRo.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_WDTH = 8
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DFLT
`endif
) (
  input  logic                       CLKip,
  input  logic                       RSTni,
  input  logic [N_REQ-1:0]           REQi,
  input  logic [N_REQ*DATA_WDTH-1:0] DATAi,
  output logic [N_REQ-1:0]           GNTo,
  output logic [N_REQ-1:0]           ACKo,
  output logic                       ERRo,
  output logic                       TX_ENo,
  output logic [DATA_WDTH-1:0]       TXo,
  input  logic                       TX_BUSYi
);

  localparam int unsigned PW = $clog2(N_REQ);

  arb_state_t           state_q, state_n;
  logic [PW-1:0]        ptr_q, ptr_n;
  logic [PW-1:0]        w_q, w_n;
  logic                 busy_q, busy_n;
  logic [N_REQ-1:0]     gnt_q, gnt_n;
  logic [N_REQ-1:0]     ack_q, ack_n;
  logic                 tx_en_q, tx_en_n;
  logic [DATA_WDTH-1:0] tx_q, tx_n;
  logic                 pick_valid;
  logic [PW-1:0]        pick_w;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_n;
  logic          err_q, err_n;
`endif

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (REQi),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .w     (pick_w)
  );

  // State and output registers.
  always_ff @(posedge CLKip or negedge RSTni) begin
    if (!RSTni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
      tx_en_q <= 1'b0;
      tx_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      w_q     <= w_n;
      busy_q  <= busy_n;
      gnt_q   <= gnt_n;
      ack_q   <= ack_n;
      tx_en_q <= tx_en_n;
      tx_q    <= tx_n;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= cnt_n;
      err_q   <= err_n;
`endif
    end
  end

  // Grant, launch, wait for frame end, release with ACK.
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    w_n     = w_q;
    busy_n  = busy_q;
    gnt_n   = gnt_q;
    ack_n   = '0;
    tx_en_n = tx_en_q;
    tx_n    = tx_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_n   = '0;
    err_n   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          w_n     = pick_w;
          gnt_n   = N_REQ'(1) << pick_w;
          tx_n    = DATAi[pick_w*DATA_WDTH +: DATA_WDTH];
          tx_en_n = 1'b1;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
`ifdef UART_ARB_TIMEOUT_EN
        cnt_n = cnt_q + CW'(1);
`endif
        // Keep TX_EN up until uart_tx reports busy through its input sync.
        if (TX_BUSYi) begin
          tx_en_n = 1'b0;
          busy_n  = 1'b1;
          state_n = WAIT_TX;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          tx_en_n = 1'b0;
          ack_n   = N_REQ'(1) << w_q;
          err_n   = 1'b1;
          state_n = RELEASE;
        end
`endif
      end
      WAIT_TX: begin
        busy_n = TX_BUSYi;
        if (busy_q && !TX_BUSYi) begin
          ack_n   = N_REQ'(1) << w_q;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        gnt_n   = '0;
        busy_n  = 1'b0;
        ptr_n   = (w_q == PW'(N_REQ - 1)) ? '0 : w_q + PW'(1);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign GNTo   = gnt_q;
  assign ACKo   = ack_q;
  assign TX_ENo = tx_en_q;
  assign TXo    = tx_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign ERRo   = err_q;
`else
  assign ERRo   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb with a behavioural uart_tx and line decoder.
// Timeout expectations follow `define UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned B  = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] idx;
    logic       err;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            err;
  logic            tx_en;
  logic [DW-1:0]   tx;
  logic            busy = 1'b0;

  uart_tx_arb #(.N_REQ(N), .DATA_WDTH(DW)) dut (
    .CLKip    (clk),
    .RSTni    (rst_n),
    .REQi     (req),
    .DATAi    (data),
    .GNTo     (gnt),
    .ACKo     (ack),
    .ERRo     (err),
    .TX_ENo   (tx_en),
    .TXo      (tx),
    .TX_BUSYi (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural uart_tx: 2-flop enable sync, 10-bit frame, B cycles per bit.
  logic       dead = 1'b0;
  logic       en1 = 1'b0, en2 = 1'b0;
  logic [9:0] sh = '1;
  logic [3:0] bc = '0;
  logic [1:0] cc = '0;
  logic [3:0] gnt_start = '0;
  logic       line;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en1 <= 1'b0; en2 <= 1'b0; busy <= 1'b0; sh <= '1; bc <= '0; cc <= '0;
    end else begin
      en1 <= tx_en;
      en2 <= en1;
      if (!busy) begin
        if (en2 && !dead) begin
          busy      <= 1'b1;
          sh        <= {1'b1, tx, 1'b0};
          bc        <= '0;
          cc        <= '0;
          gnt_start <= gnt;
        end
      end else if (cc == 2'(B - 1)) begin
        cc <= '0;
        sh <= sh >> 1;
        if (bc == 4'd9) busy <= 1'b0;
        else bc <= bc + 4'd1;
      end else begin
        cc <= cc + 2'd1;
      end
    end
  end

  assign line = busy ? sh[0] : 1'b1;

  // Serial line decoder, mid-bit sampling, LSB first.
  logic       line_q = 1'b1;
  logic       rx_act = 1'b0;
  int         rx_c = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_last = '0;

  always @(posedge clk) begin
    line_q <= line;
    if (!rx_act) begin
      if (line_q && !line) begin
        rx_act <= 1'b1;
        rx_c   <= 1;
      end
    end else begin
      rx_c <= rx_c + 1;
      if ((rx_c % B) == B / 2 && rx_c / B >= 1 && rx_c / B <= 8)
        rx_sh[3'(rx_c / B - 1)] <= line;
      if (rx_c == 9 * B + B / 2) begin
        rx_act  <= 1'b0;
        rx_last <= rx_sh;
        if (line) rx_cnt <= rx_cnt + 1;
      end
    end
  end

  exp_t       exp_q[$];
  int         rem[N];
  logic [7:0] data_r[N];
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_ack = 0;
  int         ok_acks = 0;
  int         rx_mark = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic push(input int idx, input logic [7:0] d, input logic e);
    exp_t x;
    x.idx  = 2'(idx);
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k]           = (rem[k] > 0);
      data[k*DW +: DW] = data_r[k];
    end
  endtask

  // One cycle: score any ACK at the negedge, then update producers.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (|ack) begin
      n_ack++;
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'(ack), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("ack_vec", 32'(ack), 32'(1) << e.idx);
        check("err_flag", 32'(err), 32'(e.err));
        check("tx_en_at_ack", 32'(tx_en), 32'(0));
        if (!e.err) begin
          ok_acks++;
          check("frame_byte", 32'(rx_last), 32'(e.data));
          check("frames_per_ack", 32'(rx_cnt - rx_mark), 32'(1));
          check("gnt_at_start", 32'(gnt_start), 32'(1) << e.idx);
        end
        rx_mark = rx_cnt;
      end
      for (int k = 0; k < N; k++)
        if (ack[k] && rem[k] > 0) rem[k]--;
    end
    drive();
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_drain(input string tag, input int max);
    for (int i = 0; i < max && exp_q.size() > 0; i++) step();
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin rem[k] = 0; data_r[k] = '0; end
    drive();
    step_n(2);
    check("reset_outputs", 32'({gnt, ack, err, tx_en, tx}), 32'(0));
    rst_n = 1'b1;
    step();

    // Data stability: byte latched at grant, later DATAi change ignored.
    data_r[1] = 8'h3C; rem[1] = 1; push(1, 8'h3C, 1'b0);
    for (int i = 0; i < 10 && gnt[1] !== 1'b1; i++) step();
    check("t5_grant", 32'(gnt), 32'(4'b0010));
    data_r[1] = 8'hFF;
    drive();
    wait_drain("t5_drain", 200);

    // Single request from req2.
    data_r[2] = 8'hA5; rem[2] = 1; push(2, 8'hA5, 1'b0);
    wait_drain("t2_drain", 200);
    step_n(80);
    check("t2_no_dup", 32'(rx_cnt), 32'(ok_acks));

    // Pointer at 3 with req3 and req0: 3 first, then wrap to 0.
    data_r[3] = 8'h96; data_r[0] = 8'h69; rem[3] = 1; rem[0] = 1;
    push(3, 8'h96, 1'b0); push(0, 8'h69, 1'b0);
    wait_drain("t4_drain", 300);

    // Pointer now at 1: 1011 must serve 1, 3, 0.
    data_r[1] = 8'h11; data_r[3] = 8'h33; data_r[0] = 8'hC3;
    rem[0] = 1; rem[1] = 1; rem[3] = 1;
    push(1, 8'h11, 1'b0); push(3, 8'h33, 1'b0); push(0, 8'hC3, 1'b0);
    wait_drain("t4b_drain", 400);
    step_n(60);
    check("t4_frames", 32'(rx_cnt), 32'(ok_acks));

    // uart_tx never goes busy.
    dead = 1'b1; data_r[0] = 8'h5E; rem[0] = 1;
    n0 = n_ack;
`ifdef UART_ARB_TIMEOUT_EN
    push(0, 8'h5E, 1'b1);
    step_n(100);
    check("t6_timeout_ack", 32'(exp_q.size()), 32'(0));
    check("t6_tx_en_low", 32'(tx_en), 32'(0));
`else
    step_n(100);
    check("t6_no_ack", 32'(n_ack), 32'(n0));
    check("t6_tx_en_held", 32'(tx_en), 32'(1));
    check("t6_gnt_held", 32'(gnt), 32'(4'b0001));
    check("t6_tx_latched", 32'(tx), 32'(8'h5E));
`endif

    // Asynchronous reset mid-launch clears outputs without a clock edge.
    rem[0] = 0;
    rst_n  = 1'b0;
    #1;
    check("t1_async_reset", 32'({gnt, ack, err, tx_en, tx}), 32'(0));
    dead = 1'b0;
    step_n(3);
    rst_n = 1'b1;
    rx_mark = rx_cnt;

    // All four held: order 0,1,2,3,0 from a freshly reset pointer.
    data_r[0] = 8'h10; data_r[1] = 8'h21; data_r[2] = 8'h42; data_r[3] = 8'h84;
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    push(0, 8'h10, 1'b0); push(1, 8'h21, 1'b0); push(2, 8'h42, 1'b0);
    push(3, 8'h84, 1'b0); push(0, 8'h10, 1'b0);
    wait_drain("t3_drain", 600);
    step_n(80);
    check("t3_frames", 32'(rx_cnt), 32'(ok_acks));
    check("t3_idle_gnt", 32'(gnt), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
